// File: rtl/timer_reg_if.sv
// timer_reg_if: APB register front-end for an 8-bit timer.
// Registers: TDR (reload), TCR (control), TSR (sticky status, write-0-to-clear),
// TCNT (live counter, read-only) and, when the TIMER_INT_EN macro is defined,
// TIER (interrupt enables) with registered interrupt outputs.
// Every transfer takes a fixed three cycles: SETUP, one WAIT state, then ACCESS.
module timer_reg_if (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    // APB slave
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    // counter-side controls
    output logic [7:0] tdr,
    output logic       tcr_load,
    output logic       tcr_updown,
    output logic       tcr_en,
    output logic [1:0] tcr_cks,
    // counter-side status
    input  logic [7:0] tcnt,
    input  logic       ovf_trig,
    input  logic       udf_trig,
    // interrupts
    output logic       tmr_ovf_irq,
    output logic       tmr_udf_irq
);

    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;
    localparam logic [7:0] ADDR_TIER = 8'h04;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACCESS = 2'd3
    } apb_state_t;

    apb_state_t r_state;
    logic       r_pready;
    logic       r_pslverr;

    logic [7:0] r_tdr;
    logic       r_tcr_load;
    logic       r_tcr_updown;
    logic       r_tcr_en;
    logic [1:0] r_tcr_cks;
    logic [1:0] r_tsr;          // [0] = ovf, [1] = udf

    logic       w_mapped;
    logic       w_err;
    logic       w_commit;
    logic       w_wr_tdr;
    logic       w_wr_tcr;
    logic       w_wr_tsr;
    logic [1:0] w_set;
    logic [1:0] w_tsr_next;
    logic [7:0] w_rdata;

    // Address decode: which offsets exist in this build
    always_comb begin
        w_mapped = 1'b0;
        case (paddr)
            ADDR_TDR, ADDR_TCR, ADDR_TSR, ADDR_TCNT: w_mapped = 1'b1;
`ifdef TIMER_INT_EN
            ADDR_TIER:                               w_mapped = 1'b1;
`endif
            default:                                 w_mapped = 1'b0;
        endcase
    end

    // Error on unmapped offsets and on any write to the read-only counter
    assign w_err    = !w_mapped || (pwrite && (paddr == ADDR_TCNT));
    // A write lands only in a completed, error-free ACCESS cycle
    assign w_commit = (r_state == ST_ACCESS) && psel && pwrite && !w_err;
    assign w_wr_tdr = w_commit && (paddr == ADDR_TDR);
    assign w_wr_tcr = w_commit && (paddr == ADDR_TCR);
    assign w_wr_tsr = w_commit && (paddr == ADDR_TSR);

    assign w_set = {udf_trig, ovf_trig};

    // Per-flag next state: a hardware set pulse beats a same-cycle write-0 clear
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_tsr_bit
            assign w_tsr_next[gi] = w_set[gi] | (r_tsr[gi] & ~(w_wr_tsr & ~pwdata[gi]));
        end
    endgenerate

    // APB handshake FSM; pready/pslverr are registered and live only in ACCESS
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= ST_IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (psel && !penable) begin
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_state <= psel ? ST_WAIT : ST_IDLE;
                end
                ST_WAIT: begin
                    if (psel) begin
                        r_state   <= ST_ACCESS;
                        r_pready  <= 1'b1;
                        r_pslverr <= w_err;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Software-visible registers: TDR, TCR fields and the sticky status flags
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tdr        <= 8'h00;
            r_tcr_load   <= 1'b0;
            r_tcr_updown <= 1'b0;
            r_tcr_en     <= 1'b0;
            r_tcr_cks    <= 2'b00;
            r_tsr        <= 2'b00;
        end else begin
            if (w_wr_tdr) begin
                r_tdr <= pwdata;
            end
            if (w_wr_tcr) begin
                r_tcr_load   <= pwdata[7];
                r_tcr_updown <= pwdata[5];
                r_tcr_en     <= pwdata[4];
                r_tcr_cks    <= pwdata[1:0];
            end
            r_tsr <= w_tsr_next;
        end
    end

`ifdef TIMER_INT_EN
    logic [1:0] r_tier;         // [0] = ovf_ie, [1] = udf_ie
    logic [1:0] r_irq;          // [0] = ovf, [1] = udf
    logic       w_wr_tier;
    logic [1:0] w_tier_next;

    assign w_wr_tier   = w_commit && (paddr == ADDR_TIER);
    assign w_tier_next = w_wr_tier ? pwdata[1:0] : r_tier;

    // Enables plus interrupt flops; irq is computed from next-state values so
    // it tracks TSR & TIER with no extra latency and comes straight off a flop
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tier <= 2'b00;
            r_irq  <= 2'b00;
        end else begin
            r_tier <= w_tier_next;
            r_irq  <= w_tsr_next & w_tier_next;
        end
    end

    assign tmr_ovf_irq = r_irq[0];
    assign tmr_udf_irq = r_irq[1];
`else
    assign tmr_ovf_irq = 1'b0;
    assign tmr_udf_irq = 1'b0;
`endif

    // Read mux; TCNT is taken live so the value reflects the ACCESS cycle
    always_comb begin
        w_rdata = 8'h00;
        case (paddr)
            ADDR_TDR:  w_rdata = r_tdr;
            ADDR_TCR:  w_rdata = {r_tcr_load, 1'b0, r_tcr_updown, r_tcr_en, 2'b00, r_tcr_cks};
            ADDR_TSR:  w_rdata = {6'b000000, r_tsr};
            ADDR_TCNT: w_rdata = tcnt;
`ifdef TIMER_INT_EN
            ADDR_TIER: w_rdata = {6'b000000, r_tier};
`endif
            default:   w_rdata = 8'h00;
        endcase
    end

    assign prdata     = (r_state == ST_ACCESS) ? w_rdata : 8'h00;
    assign pready     = r_pready;
    assign pslverr    = r_pslverr;
    assign tdr        = r_tdr;
    assign tcr_load   = r_tcr_load;
    assign tcr_updown = r_tcr_updown;
    assign tcr_en     = r_tcr_en;
    assign tcr_cks    = r_tcr_cks;

endmodule

// File: tb/tb_timer_reg_if.sv
// Testbench for timer_reg_if: directed register scenarios followed by random
// APB traffic, trigger pulses and aborted transfers. Expected read responses are
// queued at issue time and checked by an independent monitor on pready.
module tb_timer_reg_if;

`ifdef TIMER_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       psel = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] paddr = 8'h00;
    logic [7:0] pwdata = 8'h00;
    logic [7:0] tcnt = 8'h00;
    logic       ovf_trig = 1'b0;
    logic       udf_trig = 1'b0;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic [7:0] tdr;
    logic       tcr_load;
    logic       tcr_updown;
    logic       tcr_en;
    logic [1:0] tcr_cks;
    logic       tmr_ovf_irq;
    logic       tmr_udf_irq;

    timer_reg_if dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .tdr        (tdr),
        .tcr_load   (tcr_load),
        .tcr_updown (tcr_updown),
        .tcr_en     (tcr_en),
        .tcr_cks    (tcr_cks),
        .tcnt       (tcnt),
        .ovf_trig   (ovf_trig),
        .udf_trig   (udf_trig),
        .tmr_ovf_irq(tmr_ovf_irq),
        .tmr_udf_irq(tmr_udf_irq)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int setup_cyc = -100;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic       chk_data;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: the register file as plain byte values
    logic [7:0] m_tdr = 8'h00;
    logic [7:0] m_tcr = 8'h00;
    logic [7:0] m_tsr = 8'h00;
    logic [7:0] m_tier = 8'h00;

    function automatic logic is_mapped(input logic [7:0] a);
        return (a <= 8'h03) || (INT_EN && a == 8'h04);
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a, input logic [7:0] cnt);
        case (a)
            8'h00:   return m_tdr;
            8'h01:   return m_tcr;
            8'h02:   return m_tsr;
            8'h03:   return cnt;
            8'h04:   return INT_EN ? m_tier : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Monitor: pops an expectation on every pready and checks idle-bus outputs
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (psel && !penable) setup_cyc = cyc;
            if (pready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pready got=1 want=0 (no transfer pending)");
                end else begin
                    mon_e = exp_q.pop_front();
                    if (pslverr !== mon_e.err || (cyc - setup_cyc) != 3 ||
                        (mon_e.chk_data && prdata !== mon_e.data)) begin
                        errors++;
                        $display("FAIL xfer %s a=%02h got data=%02h err=%0b lat=%0d want data=%02h err=%0b lat=3",
                                 mon_e.wr ? "wr" : "rd", mon_e.addr, prdata, pslverr,
                                 cyc - setup_cyc, mon_e.data, mon_e.err);
                    end else begin
                        $display("txn %s a=%02h data=%02h err=%0b", mon_e.wr ? "wr" : "rd",
                                 mon_e.addr, prdata, pslverr);
                    end
                end
            end else begin
                checks++;
                if (prdata !== 8'h00 || pslverr !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_bus got prdata=%02h pslverr=%0b want 00/0", prdata, pslverr);
                end
            end
        end
    end

    task automatic check_outputs(input string tag);
        logic [7:0] want_tcr;
        logic       want_ovf;
        logic       want_udf;
        want_tcr = m_tcr;
        want_ovf = INT_EN & m_tsr[0] & m_tier[0];
        want_udf = INT_EN & m_tsr[1] & m_tier[1];
        checks++;
        if (tdr !== m_tdr || {tcr_load, tcr_updown, tcr_en, tcr_cks} !==
            {want_tcr[7], want_tcr[5], want_tcr[4], want_tcr[1:0]}) begin
            errors++;
            $display("FAIL %s_ctrl got tdr=%02h ld=%0b ud=%0b en=%0b cks=%0d want tdr=%02h tcr=%02h",
                     tag, tdr, tcr_load, tcr_updown, tcr_en, tcr_cks, m_tdr, m_tcr);
        end
        checks++;
        if (tmr_ovf_irq !== want_ovf || tmr_udf_irq !== want_udf) begin
            errors++;
            $display("FAIL %s_irq got ovf=%0b udf=%0b want ovf=%0b udf=%0b",
                     tag, tmr_ovf_irq, tmr_udf_irq, want_ovf, want_udf);
        end
    endtask

    // mode 0 = normal, 1 = psel dropped in WAIT, 2 = reset asserted in WAIT
    task automatic apb(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input int mode, input logic ovf_in_access);
        exp_t e;
        logic got;
        logic err;
        err = !is_mapped(a) || (wr && a == 8'h03);
        @(posedge sys_clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        if (mode == 0) begin
            e.wr = wr; e.addr = a; e.err = err;
            e.chk_data = !wr; e.data = wr ? 8'h00 : model_read(a, tcnt);
            exp_q.push_back(e);
        end
        @(posedge sys_clk); #1;
        penable = 1'b1;
        @(posedge sys_clk); #1;
        if (mode == 1) begin
            psel = 1'b0; penable = 1'b0;
            repeat (3) @(posedge sys_clk);
            #1;
            check_outputs("abort");
            return;
        end
        if (mode == 2) begin
            sys_rst_n = 1'b0;
            psel = 1'b0; penable = 1'b0;
            m_tdr = 8'h00; m_tcr = 8'h00; m_tsr = 8'h00; m_tier = 8'h00;
            repeat (2) @(posedge sys_clk);
            #1;
            check_outputs("in_reset");
            sys_rst_n = 1'b1;
            return;
        end
        got = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge sys_clk);
            if (pready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            errors++; checks++;
            $display("FAIL pready_timeout a=%02h got pready=0 want 1", a);
        end else if (ovf_in_access) begin
            ovf_trig = 1'b1;
        end
        @(posedge sys_clk); #1;
        psel = 1'b0; penable = 1'b0; ovf_trig = 1'b0;
        if (wr && !err) begin
            case (a)
                8'h00: m_tdr = d;
                8'h01: m_tcr = d & 8'hB3;
                8'h02: m_tsr = m_tsr & d & 8'h03;
                8'h04: m_tier = d & 8'h03;
                default: ;
            endcase
        end
        if (ovf_in_access) m_tsr = m_tsr | 8'h01;
        check_outputs(wr ? "wr" : "rd");
    endtask

    task automatic pulse(input logic ovf, input logic udf);
        @(posedge sys_clk); #1;
        ovf_trig = ovf; udf_trig = udf;
        @(posedge sys_clk); #1;
        ovf_trig = 1'b0; udf_trig = 1'b0;
        m_tsr = m_tsr | {6'b000000, udf, ovf};
        check_outputs("pulse");
    endtask

    initial begin
        int r;
        // Triggers while in reset must be ignored
        ovf_trig = 1'b1; udf_trig = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        ovf_trig = 1'b0; udf_trig = 1'b0;
        check_outputs("reset");
        checks++;
        if (prdata !== 8'h00 || pready !== 1'b0 || pslverr !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus got prdata=%02h pready=%0b pslverr=%0b want 00/0/0",
                     prdata, pready, pslverr);
        end
        sys_rst_n = 1'b1;

        // Reset values of the mapped registers
        tcnt = 8'h00;
        for (int a = 0; a < 4; a++) apb(1'b0, 8'(a), 8'h00, 0, 1'b0);

        // TDR / TCR writes and read-back
        apb(1'b1, 8'h00, 8'hA5, 0, 1'b0);
        apb(1'b1, 8'h01, 8'h80, 0, 1'b0);
        apb(1'b1, 8'h01, 8'h30, 0, 1'b0);
        apb(1'b0, 8'h01, 8'h00, 0, 1'b0);
        apb(1'b1, 8'h01, 8'hFF, 0, 1'b0);
        apb(1'b0, 8'h01, 8'h00, 0, 1'b0);

        // Sticky status, write-0 clear, set-beats-clear
        pulse(1'b0, 1'b1);
        apb(1'b0, 8'h02, 8'h00, 0, 1'b0);
        apb(1'b1, 8'h02, 8'hFD, 0, 1'b0);
        apb(1'b0, 8'h02, 8'h00, 0, 1'b0);
        apb(1'b1, 8'h02, 8'h00, 0, 1'b1);
        apb(1'b0, 8'h02, 8'h00, 0, 1'b0);

        // Error responses change nothing
        tcnt = 8'h5A;
        apb(1'b1, 8'h03, 8'h55, 0, 1'b0);
        apb(1'b0, 8'h03, 8'h00, 0, 1'b0);
        apb(1'b0, 8'h05, 8'h00, 0, 1'b0);
        apb(1'b1, 8'h05, 8'hFF, 0, 1'b0);
        for (int a = 0; a < 3; a++) apb(1'b0, 8'(a), 8'h00, 0, 1'b0);

        // Reset in WAIT of a TDR write, then a normal read
        apb(1'b1, 8'h00, 8'h3C, 2, 1'b0);
        apb(1'b0, 8'h00, 8'h00, 0, 1'b0);
        // psel dropped before ACCESS: no commit, no pready
        apb(1'b1, 8'h00, 8'h77, 1, 1'b0);
        apb(1'b0, 8'h00, 8'h00, 0, 1'b0);

        // Interrupt enables (or their absence)
        apb(1'b1, 8'h04, 8'h02, 0, 1'b0);
        apb(1'b0, 8'h04, 8'h00, 0, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        apb(1'b1, 8'h02, 8'hFD, 0, 1'b0);
        apb(1'b1, 8'h04, 8'h03, 0, 1'b0);
        apb(1'b1, 8'h02, 8'h00, 0, 1'b0);

        // Random traffic
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            tcnt = 8'($urandom);
            if (r == 0) begin
                pulse(1'($urandom), 1'($urandom));
            end else if (r == 1) begin
                apb(1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom), 1, 1'b0);
            end else begin
                apb(1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom), 0,
                    ($urandom_range(0, 7) == 0));
            end
        end

        repeat (4) @(posedge sys_clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_responses got=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
